unidad_division: RTL



---
 rtl/unidad_division_if.sv | 25 ++
 rtl/unidad_division.sv | 139 +++++++++++++
 2 files changed

// File: rtl/unidad_division_if.sv
`default_nettype none
// unidad_division_if: start/done handshake and operand/result bus of the iterative divider.
interface unidad_division_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             Kill;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;

   modport master (
      output Start, Op, OperandA, OperandB, Kill,
      input  Busy, Done, Result
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, Kill,
      output Busy, Done, Result
   );
endinterface
`default_nettype wire

// File: rtl/unidad_division.sv
`default_nettype none
// unidad_division: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Rev 1.0
module unidad_division #(
   parameter int WIDTH = 32
) (
   input  wire logic         CLK,
   input  wire logic         RESET,
   unidad_division_if.slave  bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] div_q;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] cnt_q;
   logic             op_rem_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             busy_q;
   logic             done_q;

   logic             sgn_d;
   logic [WIDTH-1:0] abs_a_d;
   logic [WIDTH-1:0] abs_b_d;
   logic             zero_div_d;
   logic             ovf_d;
   logic [WIDTH-1:0] special_res_d;
   logic [WIDTH:0]   shift_d;
   logic             ge_d;
   logic [WIDTH-1:0] rem_d;
   logic [WIDTH-1:0] quo_d;
   logic [WIDTH-1:0] fix_d;

   // Operand conditioning evaluated on the pins, used only on the capture edge.
   always_comb begin
      sgn_d         = ~bus.Op[0];
      abs_a_d       = (sgn_d && bus.OperandA[WIDTH-1]) ? -bus.OperandA : bus.OperandA;
      abs_b_d       = (sgn_d && bus.OperandB[WIDTH-1]) ? -bus.OperandB : bus.OperandB;
      zero_div_d    = (bus.OperandB == '0);
      ovf_d         = sgn_d && (bus.OperandA == {1'b1, {(WIDTH-1){1'b0}}})
                            && (bus.OperandB == '1);
      special_res_d = '0;
      if (zero_div_d) begin
         special_res_d = bus.Op[1] ? bus.OperandA : '1;
      end else if (ovf_d) begin
         special_res_d = bus.Op[1] ? '0 : bus.OperandA;
      end
   end

   // One restoring step; rem_q < div_q always, so the shifted value fits WIDTH+1 bits.
   always_comb begin
      shift_d = {rem_q, quo_q[WIDTH-1]};
      ge_d    = (shift_d >= {1'b0, div_q});
      rem_d   = ge_d ? (shift_d[WIDTH-1:0] - div_q) : shift_d[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge_d};
      if (op_rem_q) begin
         fix_d = rneg_q ? -rem_d : rem_d;
      end else begin
         fix_d = qneg_q ? -quo_d : quo_d;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         quo_q    <= '0;
         rem_q    <= '0;
         div_q    <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         op_rem_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (bus.Start && !bus.Kill) begin
                  op_rem_q <= bus.Op[1];
                  qneg_q   <= sgn_d && (bus.OperandA[WIDTH-1] ^ bus.OperandB[WIDTH-1]);
                  rneg_q   <= sgn_d && bus.OperandA[WIDTH-1];
                  quo_q    <= abs_a_d;
                  div_q    <= abs_b_d;
                  rem_q    <= '0;
                  cnt_q    <= '0;
                  if (zero_div_d || ovf_d) begin
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                     result_q <= special_res_d;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               if (bus.Kill) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  quo_q <= quo_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_ITER) begin
                     state_q  <= S_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= fix_d;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy   = busy_q;
   assign bus.Done   = done_q;
   assign bus.Result = result_q;

endmodule
`default_nettype wire
